robs_microseq: RTL and testbench
================================

ROBS_MICROSEQ -- requirements
Module: robs_microseq

Interface
REQ-001 SHALL have parameter UPC_W, default 5: micro-PC width.
REQ-002 SHALL have parameter CTRL_W, default 15: control-word width.
REQ-003 SHALL have parameter NUM_COND, default 3: external condition inputs.
REQ-004 SHALL have parameter CS_W, default 3: condition-select field width.
REQ-005 SHALL have parameter CNT_W, default 6: loop-counter width.
REQ-006 SHALL have parameter STACK_DEPTH, default 2: return-stack entries.
REQ-007 SHALL have parameter START_ADDR, default 0: first microinstruction of a run.
REQ-008 SHALL use derived UI_W = 3+CS_W+1+UPC_W+CTRL_W; uinstr fields are {op[2:0], sel[CS_W-1:0], inv, nxt[UPC_W-1:0], ctl[CTRL_W-1:0]} (MSB first).
REQ-009 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-010 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port start  input  1  run request.
REQ-012 SHALL have port cond  input  NUM_COND  datapath status flags (e.g. zq, zr, zy).
REQ-013 SHALL have port uaddr  output  UPC_W  control-memory address, equal to upc.
REQ-014 SHALL have port uinstr  input  UI_W  control-memory data, combinational in uaddr.
REQ-015 SHALL have port c  output  CTRL_W  datapath control word.
REQ-016 SHALL have port busy  output  1  high while in RUN.
REQ-017 SHALL have port done  output  1  high while in DONE.
REQ-018 SHALL have port err  output  1  sticky stack-fault flag.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE; busy=(RUN), done=(DONE).
REQ-020 SHALL accept start in IDLE or DONE: next cycle RUN, upc=START_ADDR, err=0, sp=0; start in RUN ignored.
REQ-021 SHALL drive c=ctl while in RUN and c=0 in IDLE/DONE.
REQ-022 SHALL execute one microinstruction per RUN cycle; condition t = (sel==0 ? 0 : sel<=NUM_COND ? cond[sel-1] : 1) XOR inv.
REQ-023 SHALL implement op 000 BR: upc <= t ? nxt : upc+1.
REQ-024 SHALL implement op 001 CALL: push upc+1, upc <= nxt (unconditional).
REQ-025 SHALL implement op 010 RET: pop into upc.
REQ-026 SHALL implement op 011 LDCNT: cnt <= zero-extended nxt, upc <= upc+1.
REQ-027 SHALL implement op 100 DJNZ: if cnt!=0, cnt <= cnt-1 and upc <= (cnt-1!=0) ? nxt : upc+1; if cnt==0, cnt unchanged and upc <= upc+1.
REQ-028 SHALL implement op 101 HALT: ctl still drives c that cycle, next cycle DONE; upc holds.
REQ-029 SHALL treat ops 110/111 as BR with t forced 0 (NOP).
REQ-030 SHALL wrap upc+1 modulo 2^UPC_W.
REQ-031 SHALL on CALL with sp==STACK_DEPTH (full), or RET with sp==0 (empty), set err=1, leave stack unchanged and go to DONE next cycle.
REQ-032 SHALL keep err high until the next accepted start or reset.
REQ-033 SHALL leave cnt unaffected by start; only LDCNT/DJNZ and reset modify it.

Reset
REQ-034 SHALL, on reset low at any time including mid-run, immediately force state=IDLE, upc=0, cnt=0, sp=0, err=0, c=0, busy=0, done=0.
REQ-035 SHALL resume in IDLE after reset deasserts and wait for start.

Verification
REQ-036 SHALL verify Robertson program: ROM at 0..17 with HALT at 17, start pulse -> busy next cycle, c follows ROM ctl, done=1 the cycle after HALT executes, c=0.
REQ-037 SHALL verify loop: LDCNT nxt=4, then DJNZ to itself -> DJNZ executes 4 times, cnt ends 0, falls through to upc+1.
REQ-038 SHALL verify condition: BR sel=1 inv=1 with cond[0]=0 -> jumps to nxt; cond[0]=1 -> upc+1.
REQ-039 SHALL verify stack: CALL, CALL, CALL with STACK_DEPTH=2 -> third CALL gives err=1, DONE; RET at sp=0 -> err=1; next start clears err.
REQ-040 SHALL verify async reset: reset low mid-RUN between clock edges -> busy=0, c=0, upc=0 without waiting for clk.
REQ-041 SHALL verify wrap: UPC_W=5, BR not-taken at upc=31 -> upc=0.

Source files
------------

// File: rtl/robs_microseq.sv
// Microprogram sequencer: each RUN cycle fetches one microinstruction at upc,
// drives its control word and picks the next upc (branch, call/return, counted loop).
//
// state | meaning
// IDLE  | waiting for start after reset, c=0
// RUN   | one microinstruction executed per cycle, c=ctl
// DONE  | halted or stack fault, c=0, start restarts

module robs_microseq #(
    parameter int UPC_W       = 5,
    parameter int CTRL_W      = 15,
    parameter int NUM_COND    = 3,
    parameter int CS_W        = 3,
    parameter int CNT_W       = 6,
    parameter int STACK_DEPTH = 2,
    parameter int START_ADDR  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_COND-1:0]               cond,
    output logic [UPC_W-1:0]                  uaddr,
    input  logic [3+CS_W+1+UPC_W+CTRL_W-1:0]  uinstr,
    output logic [CTRL_W-1:0]                 c,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int UI_W = 3 + CS_W + 1 + UPC_W + CTRL_W;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_BR    = 3'b000;
    localparam logic [2:0] OP_CALL  = 3'b001;
    localparam logic [2:0] OP_RET   = 3'b010;
    localparam logic [2:0] OP_LDCNT = 3'b011;
    localparam logic [2:0] OP_DJNZ  = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [UPC_W-1:0]   upc, upc_nxt, upc_inc, pop_val;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_dec;
    logic [SP_W-1:0]    sp, sp_nxt;
    logic               err_q, err_nxt;
    logic               push;
    logic [UPC_W-1:0]   stack [STACK_DEPTH];

    logic [2:0]         op;
    logic [CS_W-1:0]    sel;
    logic               inv;
    logic [UPC_W-1:0]   nxt;
    logic [CTRL_W-1:0]  ctl;
    logic               t_raw, t;

    assign op  = uinstr[UI_W-1 -: 3];
    assign sel = uinstr[UI_W-4 -: CS_W];
    assign inv = uinstr[UPC_W+CTRL_W];
    assign nxt = uinstr[CTRL_W +: UPC_W];
    assign ctl = uinstr[CTRL_W-1:0];

    assign upc_inc = upc + UPC_W'(1);
    assign cnt_dec = cnt - CNT_W'(1);

    // sel=0 is constant false, sel beyond the condition inputs is constant true
    always_comb begin
        t_raw = (sel != '0);
        for (int i = 0; i < NUM_COND; i++) begin
            if (sel == CS_W'(i + 1)) t_raw = cond[i];
        end
        t = t_raw ^ inv;
    end

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) pop_val = stack[i];
        end
    end

    always_comb begin
        state_nxt = state;
        upc_nxt   = upc;
        cnt_nxt   = cnt;
        sp_nxt    = sp;
        err_nxt   = err_q;
        push      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    upc_nxt   = UPC_W'(START_ADDR);
                    err_nxt   = 1'b0;
                    sp_nxt    = '0;
                end
            end
            RUN: begin
                case (op)
                    OP_BR:    upc_nxt = t ? nxt : upc_inc;
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            err_nxt   = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            push    = 1'b1;
                            sp_nxt  = sp + SP_W'(1);
                            upc_nxt = nxt;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            err_nxt   = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            sp_nxt  = sp - SP_W'(1);
                            upc_nxt = pop_val;
                        end
                    end
                    OP_LDCNT: begin
                        cnt_nxt = CNT_W'(nxt);
                        upc_nxt = upc_inc;
                    end
                    OP_DJNZ: begin
                        if (cnt != '0) begin
                            cnt_nxt = cnt_dec;
                            upc_nxt = (cnt_dec != '0) ? nxt : upc_inc;
                        end else begin
                            upc_nxt = upc_inc;
                        end
                    end
                    OP_HALT:  state_nxt = DONE;
                    default:  upc_nxt = upc_inc;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            upc   <= '0;
            cnt   <= '0;
            sp    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            state <= state_nxt;
            upc   <= upc_nxt;
            cnt   <= cnt_nxt;
            sp    <= sp_nxt;
            err_q <= err_nxt;
            if (push) begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (sp == SP_W'(i)) stack[i] <= upc_inc;
                end
            end
        end
    end

    assign uaddr = upc;
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign err   = err_q;
    assign c     = busy ? ctl : '0;

endmodule

// File: tb/tb_robs_microseq.sv
// Bench for robs_microseq: programs are loaded into a behavioural ROM and the
// expected per-cycle trace is queued, then popped and compared on each falling edge.

module tb_robs_microseq;

    localparam int UPC_W  = 5;
    localparam int CTRL_W = 15;
    localparam int NCOND  = 3;
    localparam int CS_W   = 3;
    localparam int UI_W   = 3 + CS_W + 1 + UPC_W + CTRL_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NCOND-1:0]  cond;
    logic [UPC_W-1:0]  uaddr;
    logic [UI_W-1:0]   uinstr;
    logic [CTRL_W-1:0] c;
    logic              busy, done, err;

    logic [UI_W-1:0]   rom [0:31];
    assign uinstr = rom[uaddr];

    robs_microseq #(
        .UPC_W(5), .CTRL_W(15), .NUM_COND(3), .CS_W(3),
        .CNT_W(6), .STACK_DEPTH(2), .START_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cond(cond),
        .uaddr(uaddr), .uinstr(uinstr), .c(c),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [UPC_W-1:0]  ua;
        logic [CTRL_W-1:0] cw;
        logic              busy;
        logic              done;
        logic              err;
    } exp_t;

    typedef struct {
        logic [2:0]       op;
        logic [CS_W-1:0]  sel;
        logic             inv;
        logic [NCOND-1:0] cnd;
        logic             taken;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[12];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [UI_W-1:0] mk(logic [2:0] op, logic [2:0] sel, logic inv,
                                            logic [4:0] nxt, logic [14:0] ctl);
        return {op, sel, inv, nxt, ctl};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic exp_run(logic [4:0] ua, logic [14:0] cw);
        sbq.push_back('{ua: ua, cw: cw, busy: 1'b1, done: 1'b0, err: 1'b0});
    endtask

    task automatic exp_done(logic [4:0] ua, logic e);
        sbq.push_back('{ua: ua, cw: 15'h0, busy: 1'b0, done: 1'b1, err: e});
    endtask

    task automatic load_default();
        for (int i = 0; i < 32; i++) rom[i] = mk(3'd6, 3'd0, 1'b0, 5'd0, 15'h4000 + 15'(i));
    endtask

    task automatic check_outputs(string tag, logic [4:0] ua, logic [14:0] cw,
                                 logic b, logic d, logic e);
        check({tag, ".uaddr"}, 32'(uaddr), 32'(ua));
        check({tag, ".c"},     32'(c),     32'(cw));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".err"},   32'(err),   32'(e));
    endtask

    // start pulse, then one popped record per cycle; bounded by the queue length
    task automatic go(string tag);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            check_outputs(tag, e.ua, e.cw, e.busy, e.done, e.err);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cond  = '0;
        load_default();

        #12;
        check_outputs("reset", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("idle", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);

        // straight-line program, HALT at 17
        load_default();
        for (int i = 0; i < 17; i++) rom[i] = mk(3'd6, 3'd0, 1'b0, 5'd0, 15'h1000 + 15'(i));
        rom[5]  = mk(3'd0, 3'd0, 1'b0, 5'd20, 15'h1005);
        rom[8]  = mk(3'd0, 3'd7, 1'b0, 5'd9,  15'h1008);
        rom[17] = mk(3'd5, 3'd0, 1'b0, 5'd0,  15'h7E11);
        for (int i = 0; i < 17; i++) exp_run(5'(i), 15'h1000 + 15'(i));
        exp_run(5'd17, 15'h7E11);
        exp_done(5'd17, 1'b0);
        exp_done(5'd17, 1'b0);
        go("prog");

        // counted loop: DJNZ runs 4 times, then a DJNZ at cnt=0 falls through
        load_default();
        rom[0] = mk(3'd3, 3'd0, 1'b0, 5'd4, 15'h0001);
        rom[1] = mk(3'd4, 3'd0, 1'b0, 5'd1, 15'h0002);
        rom[2] = mk(3'd4, 3'd0, 1'b0, 5'd7, 15'h0003);
        rom[3] = mk(3'd5, 3'd0, 1'b0, 5'd0, 15'h0004);
        exp_run(5'd0, 15'h0001);
        for (int i = 0; i < 4; i++) exp_run(5'd1, 15'h0002);
        exp_run(5'd2, 15'h0003);
        exp_run(5'd3, 15'h0004);
        exp_done(5'd3, 1'b0);
        go("loop");

        // cnt survives a restart
        load_default();
        rom[0] = mk(3'd3, 3'd0, 1'b0, 5'd2, 15'h0031);
        rom[1] = mk(3'd5, 3'd0, 1'b0, 5'd0, 15'h0032);
        exp_run(5'd0, 15'h0031);
        exp_run(5'd1, 15'h0032);
        exp_done(5'd1, 1'b0);
        go("ldcnt");
        rom[0] = mk(3'd4, 3'd0, 1'b0, 5'd0, 15'h0041);
        rom[1] = mk(3'd5, 3'd0, 1'b0, 5'd0, 15'h0042);
        exp_run(5'd0, 15'h0041);
        exp_run(5'd0, 15'h0041);
        exp_run(5'd1, 15'h0042);
        exp_done(5'd1, 1'b0);
        go("cntkeep");

        // condition select / invert table
        vt[0]  = '{op: 3'd0, sel: 3'd1, inv: 1'b1, cnd: 3'b000, taken: 1'b1};
        vt[1]  = '{op: 3'd0, sel: 3'd1, inv: 1'b1, cnd: 3'b001, taken: 1'b0};
        vt[2]  = '{op: 3'd0, sel: 3'd1, inv: 1'b0, cnd: 3'b001, taken: 1'b1};
        vt[3]  = '{op: 3'd0, sel: 3'd2, inv: 1'b0, cnd: 3'b010, taken: 1'b1};
        vt[4]  = '{op: 3'd0, sel: 3'd2, inv: 1'b0, cnd: 3'b101, taken: 1'b0};
        vt[5]  = '{op: 3'd0, sel: 3'd3, inv: 1'b0, cnd: 3'b100, taken: 1'b1};
        vt[6]  = '{op: 3'd0, sel: 3'd0, inv: 1'b0, cnd: 3'b111, taken: 1'b0};
        vt[7]  = '{op: 3'd0, sel: 3'd0, inv: 1'b1, cnd: 3'b000, taken: 1'b1};
        vt[8]  = '{op: 3'd0, sel: 3'd7, inv: 1'b0, cnd: 3'b000, taken: 1'b1};
        vt[9]  = '{op: 3'd0, sel: 3'd4, inv: 1'b1, cnd: 3'b111, taken: 1'b0};
        vt[10] = '{op: 3'd6, sel: 3'd7, inv: 1'b0, cnd: 3'b111, taken: 1'b0};
        vt[11] = '{op: 3'd7, sel: 3'd0, inv: 1'b1, cnd: 3'b000, taken: 1'b0};
        for (int k = 0; k < 12; k++) begin
            load_default();
            rom[0] = mk(vt[k].op, vt[k].sel, vt[k].inv, 5'd5, 15'h0011);
            rom[1] = mk(3'd5, 3'd0, 1'b0, 5'd0, 15'h0022);
            rom[5] = mk(3'd5, 3'd0, 1'b0, 5'd0, 15'h0055);
            cond = vt[k].cnd;
            exp_run(5'd0, 15'h0011);
            if (vt[k].taken) begin
                exp_run(5'd5, 15'h0055);
                exp_done(5'd5, 1'b0);
            end else begin
                exp_run(5'd1, 15'h0022);
                exp_done(5'd1, 1'b0);
            end
            go($sformatf("cond%0d", k));
        end
        cond = '0;

        // nested call/return
        load_default();
        rom[0]  = mk(3'd1, 3'd0, 1'b0, 5'd10, 15'h0001);
        rom[10] = mk(3'd1, 3'd0, 1'b0, 5'd20, 15'h0002);
        rom[20] = mk(3'd2, 3'd0, 1'b0, 5'd0,  15'h0003);
        rom[11] = mk(3'd2, 3'd0, 1'b0, 5'd0,  15'h0004);
        rom[1]  = mk(3'd5, 3'd0, 1'b0, 5'd0,  15'h0005);
        exp_run(5'd0, 15'h0001);
        exp_run(5'd10, 15'h0002);
        exp_run(5'd20, 15'h0003);
        exp_run(5'd11, 15'h0004);
        exp_run(5'd1, 15'h0005);
        exp_done(5'd1, 1'b0);
        go("callret");

        // third CALL overflows a two-entry stack
        load_default();
        rom[0] = mk(3'd1, 3'd0, 1'b0, 5'd4,  15'h0001);
        rom[4] = mk(3'd1, 3'd0, 1'b0, 5'd8,  15'h0002);
        rom[8] = mk(3'd1, 3'd0, 1'b0, 5'd12, 15'h0003);
        exp_run(5'd0, 15'h0001);
        exp_run(5'd4, 15'h0002);
        exp_run(5'd8, 15'h0003);
        exp_done(5'd8, 1'b1);
        exp_done(5'd8, 1'b1);
        go("overflow");

        // RET on empty stack; the start also clears the previous err
        load_default();
        rom[0] = mk(3'd2, 3'd0, 1'b0, 5'd0, 15'h0009);
        exp_run(5'd0, 15'h0009);
        exp_done(5'd0, 1'b1);
        go("underflow");

        #2 reset = 1'b0;
        #1 check_outputs("rst_done", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // wrap from 31 to 0, then async reset mid-run
        load_default();
        rom[0] = mk(3'd0, 3'd7, 1'b0, 5'd30, 15'h0101);
        exp_run(5'd0,  15'h0101);
        exp_run(5'd30, 15'h401E);
        exp_run(5'd31, 15'h401F);
        exp_run(5'd0,  15'h0101);
        exp_run(5'd30, 15'h401E);
        go("wrap");
        #2 reset = 1'b0;
        #1 check_outputs("rst_run", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("post_rst1", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs("post_rst2", 5'd0, 15'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
